// File: rtl/fifo8_ctrl_pkg.sv
`default_nettype none
// fifo8_ctrl_pkg -- state encoding and sizing shared by the fifo8 controller.
// Rev 1.0
package fifo8_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam int OBUF_DEPTH = 2;
  localparam int CNT_W      = 2;
  localparam int FIFO_CAP   = 255;

endpackage
`default_nettype wire

// File: rtl/fifo8_ctrl_rr_arbiter.sv
`default_nettype none
// rr_arbiter -- combinational round-robin pick starting at ptr_i, with wrap.
// Rev 1.0
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int RR_W = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic            en_i,
  input  logic [RR_W-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [RR_W-1:0] next_ptr_o,
  output logic            any_o
);

  always_comb begin
    grant_o    = '0;
    next_ptr_o = ptr_i;
    any_o      = 1'b0;
    // Outer loop walks priority order; inner loop keeps every index a constant.
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (en_i && !any_o && valid_i[i] && (i == ((int'(ptr_i) + k) % NREQ))) begin
          any_o      = 1'b1;
          grant_o[i] = 1'b1;
          next_ptr_o = RR_W'((i + 1) % NREQ);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo8_ctrl.sv
`default_nettype none
// fifo8_ctrl -- write arbitration, read sequencing, output buffering and flush for a fifo8.
// Rev 1.0
module fifo8_ctrl
  import fifo8_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int RR_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [7:0]        fifo_data_o,
  output logic              fifo_write_o,
  output logic              fifo_read_o,
  input  logic [7:0]        fifo_dout_i,
  input  logic              fifo_full_i,
  input  logic              fifo_empty_i,
  output logic [7:0]        out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  input  logic              flush_i,
  output logic              flush_busy_o
);

  state_e           state_q, state_d;
  logic [RR_W-1:0]  ptr_q, ptr_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       buf0_q, buf0_d;
  logic [7:0]       buf1_q, buf1_d;

  logic             run_w;
  logic             arb_en_w;
  logic             any_w;
  logic             pop_w;
  logic             rd_ok_w;
  logic [NREQ-1:0]  grant_w;
  logic [RR_W-1:0]  next_ptr_w;
  logic [CNT_W-1:0] cnt_pop_w;
  logic [CNT_W:0]   occ_w;

  assign run_w    = (state_q == ST_RUN);
  // Gating with rst_ni keeps the FIFO strobes quiet while reset is held.
  assign arb_en_w = run_w && !fifo_full_i && rst_ni;
  assign rd_ok_w  = !fifo_empty_i && rst_ni;

  rr_arbiter #(
    .NREQ (NREQ),
    .RR_W (RR_W)
  ) u_arb (
    .valid_i    (req_valid_i),
    .en_i       (arb_en_w),
    .ptr_i      (ptr_q),
    .grant_o    (grant_w),
    .next_ptr_o (next_ptr_w),
    .any_o      (any_w)
  );

  assign req_ready_o  = grant_w;
  assign fifo_write_o = any_w;

  always_comb begin
    fifo_data_o = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_w[i]) fifo_data_o = req_data_i[8*i +: 8];
    end
  end

  assign out_valid_o  = run_w && (cnt_q != '0);
  assign out_data_o   = buf0_q;
  assign flush_busy_o = !run_w;
  assign pop_w        = out_valid_o && out_ready_i;

  // Occupancy after this cycle's pop plus the byte already on its way back.
  assign cnt_pop_w   = cnt_q - CNT_W'(pop_w);
  assign occ_w       = {1'b0, cnt_pop_w} + (CNT_W+1)'(inflight_q);
  assign fifo_read_o = rd_ok_w && (!run_w || (occ_w < (CNT_W+1)'(OBUF_DEPTH)));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    inflight_d = fifo_read_o;
    unique case (state_q)
      ST_RUN: begin
        if (any_w) ptr_d = next_ptr_w;
        if (pop_w) buf0_d = buf1_q;
        if (inflight_q) begin
          if (cnt_pop_w == '0) buf0_d = fifo_dout_i;
          else                 buf1_d = fifo_dout_i;
        end
        cnt_d = cnt_pop_w + CNT_W'(inflight_q);
        if (flush_i) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        cnt_d = '0;
        if (fifo_empty_i && !inflight_q) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_RUN;
      ptr_q      <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      buf0_q     <= 8'h00;
      buf1_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo8_ctrl.sv
`default_nettype none
// tb_fifo8_ctrl -- directed and randomized bench for fifo8_ctrl with a fifo8 model.
// Rev 1.0
module tb_fifo8_ctrl;
  import fifo8_ctrl_pkg::*;

  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        fifo_data;
  logic              fifo_write;
  logic              fifo_read;
  logic [7:0]        fifo_dout = 8'h00;
  logic              fifo_full = 1'b0;
  logic              fifo_empty = 1'b1;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              flush = 1'b0;
  logic              flush_busy;

  fifo8_ctrl #(.NREQ(NREQ), .RR_W(2)) dut (
    .clk_i (clk), .rst_ni (rst_n),
    .req_valid_i (req_valid), .req_data_i (req_data), .req_ready_o (req_ready),
    .fifo_data_o (fifo_data), .fifo_write_o (fifo_write), .fifo_read_o (fifo_read),
    .fifo_dout_i (fifo_dout), .fifo_full_i (fifo_full), .fifo_empty_i (fifo_empty),
    .out_data_o (out_data), .out_valid_o (out_valid), .out_ready_i (out_ready),
    .flush_i (flush), .flush_busy_o (flush_busy)
  );

  always #5 clk = ~clk;

  // fifo8 model: registered read data and flags, no reset.
  logic [7:0] fq[$];
  always @(posedge clk) begin
    logic [7:0] t;
    if (fifo_read && fq.size() > 0) begin
      t = fq.pop_front();
      fifo_dout <= t;
    end
    if (fifo_write && fq.size() < FIFO_CAP) fq.push_back(fifo_data);
    fifo_empty <= (fq.size() == 0);
    fifo_full  <= (fq.size() == FIFO_CAP);
  end

  int n_checks = 0;
  int n_err = 0;
  logic [7:0]      exp_q[$];
  logic [7:0]      del_q[$];
  int              m_ptr = 0;
  bit              m_busy = 0;
  bit              m_rd_prev = 0;
  bit              prev_stall = 0;
  logic [7:0]      prev_data = 8'h00;
  logic [NREQ-1:0] last_grant = '0;
  bit              last_ov = 0;
  logic [7:0]      last_od = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: entered at a negedge with inputs already driven, leaves at the next negedge.
  task automatic tick();
    logic [NREQ-1:0] g;
    int              gi;
    logic [7:0]      wd, pd;
    bit              pop, e, r;
    #1;
    g  = '0;
    gi = -1;
    if (!m_busy && !fifo_full)
      for (int k = 0; k < NREQ; k++)
        if (gi < 0 && req_valid[(m_ptr + k) % NREQ]) gi = (m_ptr + k) % NREQ;
    wd = 8'h00;
    if (gi >= 0) begin
      g[gi] = 1'b1;
      wd    = req_data[8*gi +: 8];
    end
    chk("req_ready", 32'(req_ready), 32'(g));
    chk("fifo_write", 32'(fifo_write), 32'(gi >= 0));
    chk("fifo_data", 32'(fifo_data), 32'(wd));
    chk("flush_busy", 32'(flush_busy), 32'(m_busy));
    if (m_busy) chk("busy_out_valid", 32'(out_valid), 32'd0);
    if (fifo_empty) chk("read_when_empty", 32'(fifo_read), 32'd0);
    if (prev_stall && out_valid) chk("stall_stable", 32'(out_data), 32'(prev_data));
    pop = out_valid && out_ready;
    pd  = out_data;
    e   = fifo_empty;
    r   = fifo_read;
    last_grant = g;
    last_ov    = out_valid;
    last_od    = out_data;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    @(posedge clk);
    if (pop) begin
      del_q.push_back(pd);
      chk("pop_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("out_order", 32'(pd), 32'(exp_q.pop_front()));
    end
    if (gi >= 0) begin
      exp_q.push_back(wd);
      m_ptr = (gi + 1) % NREQ;
    end
    if (m_busy) begin
      if (e && !m_rd_prev) m_busy = 0;
    end else if (flush) begin
      m_busy = 1;
      exp_q.delete();
      prev_stall = 0;
    end
    m_rd_prev = r;
    @(negedge clk);
  endtask

  task automatic drain(input int max_cycles, input string tag);
    int n = 0;
    req_valid = '0;
    out_ready = 1'b1;
    flush     = 1'b0;
    while ((exp_q.size() != 0 || fq.size() != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_flush_busy"}, 32'(flush_busy), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_fifo_write"}, 32'(fifo_write), 32'd0);
    chk({tag, "_fifo_read"}, 32'(fifo_read), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc, tp;
    logic [7:0] s0, s1;

    // Reset state with inputs active.
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    reset_check("rst");
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Round robin, both requesters held valid; also steady-state throughput.
    s0 = 8'h10; s1 = 8'h20; tp = 0;
    req_valid = 2'b11;
    out_ready = 1'b1;
    del_q.delete();
    for (int c = 0; c < 20; c++) begin
      req_data = {s1, s0};
      tick();
      if (last_grant[0]) s0++;
      if (last_grant[1]) s1++;
      if (c >= 5 && last_ov) tp++;
    end
    chk("throughput", 32'(tp), 32'd15);
    drain(100, "rr");
    chk("rr_seq0", 32'(del_q[0]), 32'h10);
    chk("rr_seq1", 32'(del_q[1]), 32'h20);
    chk("rr_seq2", 32'(del_q[2]), 32'h11);
    chk("rr_seq3", 32'(del_q[3]), 32'h21);

    // Single write latency: visible exactly three cycles later.
    req_valid = 2'b01;
    req_data  = 16'h00A5;
    tick();
    chk("lat_c0", 32'(last_ov), 32'd0);
    req_valid = '0;
    tick();
    chk("lat_c1", 32'(last_ov), 32'd0);
    tick();
    chk("lat_c2", 32'(last_ov), 32'd0);
    tick();
    chk("lat_c3", 32'(last_ov), 32'd1);
    chk("lat_data", 32'(last_od), 32'hA5);
    tick();
    chk("lat_empty", 32'(fifo_empty), 32'd1);

    // Backpressure: out_ready alternates during a 16-byte burst.
    del_q.delete();
    n = 0;
    for (int c = 0; c < 80 && n < 16; c++) begin
      req_valid = 2'b01;
      req_data  = {8'h00, 8'(n)};
      out_ready = (c % 2 == 0);
      tick();
      if (last_grant[0]) n++;
    end
    drain(100, "bp");
    chk("bp_count", 32'(del_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) chk("bp_byte", 32'(del_q[i]), 32'(i));

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom_range(0, 3));
      req_data  = 16'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 60) == 0);
      tick();
    end
    flush = 1'b0;
    drain(700, "rand");

    // Full boundary: nothing drains, 255 FIFO + 2 buffer entries accepted.
    out_ready = 1'b0;
    req_valid = 2'b01;
    acc = 0;
    for (int c = 0; c < 300; c++) begin
      req_data = {8'h00, 8'(c)};
      tick();
      if (last_grant[0]) acc++;
    end
    chk("full_accepted", 32'(acc), 32'd257);
    del_q.delete();
    drain(700, "full");
    chk("full_delivered", 32'(del_q.size()), 32'd257);

    // Flush mid-stream with a write in the flush cycle.
    out_ready = 1'b0;
    req_valid = 2'b01;
    n = 0;
    for (int c = 0; c < 30 && n < 10; c++) begin
      req_data = {8'h00, 8'(8'h30 + n)};
      tick();
      if (last_grant[0]) n++;
    end
    req_valid = '0;
    repeat (4) tick();
    flush     = 1'b1;
    req_valid = 2'b01;
    req_data  = 16'h0077;
    tick();
    flush    = 1'b0;
    req_data = 16'h005A;
    chk("flush_entered", 32'(flush_busy), 32'd1);
    n = 0;
    while (m_busy && n < 60) begin
      tick();
      if (last_grant[0]) req_valid = '0;
      n++;
    end
    chk("flush_done", 32'(m_busy), 32'd0);
    for (int c = 0; c < 5 && req_valid[0]; c++) begin
      tick();
      if (last_grant[0]) req_valid = '0;
    end
    del_q.delete();
    drain(50, "flush");
    chk("flush_count", 32'(del_q.size()), 32'd1);
    chk("flush_byte", 32'(del_q[0]), 32'h5A);

    // Reset mid-operation: 3 bytes in the FIFO, 2 in the buffer.
    out_ready = 1'b0;
    req_valid = 2'b01;
    n = 0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      req_data = {8'h00, 8'(8'hC0 + n)};
      tick();
      if (last_grant[0]) n++;
    end
    req_valid = '0;
    repeat (6) tick();
    chk("pre_rst_fifo", 32'(fq.size()), 32'd3);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    reset_check("async_rst");
    exp_q      = fq;
    m_ptr      = 0;
    m_busy     = 0;
    m_rd_prev  = 0;
    prev_stall = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    del_q.delete();
    drain(50, "rst");
    chk("rst_count", 32'(del_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("rst_byte", 32'(del_q[i]), 32'(8'hC2 + i));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo8_ctrl.md
Name: fifo8_ctrl

Overview:
Sequencing and arbitration controller for one fifo8 byte FIFO (255 usable entries, no reset of its own, registered read data). It shares the FIFO write port between up to 4 byte producers using a round-robin arbiter. It drains the read port into a valid/ready consumer stream through a 2-entry output buffer. It also provides a flush sequence, which is the only way to empty the FIFO under control.

Parameters:
NREQ, 2, number of write requesters (1..4)
RR_W, 2, width of the round-robin pointer (fixed 2; covers NREQ ≤ 4)

Ports:
CLK  in  1  system clock; all logic on posedge
RST_N  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester byte valid
req_data  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i]
req_ready  out  NREQ  one-hot grant; combinational
fifo_data  out  8  to fifo8 dataIn
fifo_write  out  1  to fifo8 write
fifo_read  out  1  to fifo8 read
fifo_dout  in  8  from fifo8 dataOut
fifo_full  in  1  from fifo8 full
fifo_empty  in  1  from fifo8 empty
out_data  out  8  consumer byte
out_valid  out  1  consumer valid
out_ready  in  1  consumer ready
flush  in  1  single-cycle flush request
flush_busy  out  1  high while flushing

Behaviour:
- Reset values:
  - out_valid=0, out_data=0x00, flush_busy=0.
  - Round-robin pointer=0, in-flight flag=0, output buffer count=0.
  - fifo_write, fifo_read and req_ready are 0 while RST_N=0.
- The FIFO is not cleared by RST_N. Any bytes already in it are drained normally after reset.
- State machine: RUN and FLUSH. Reset state is RUN.
- Write arbitration (RUN only):
  - Grant goes to the first requester with req_valid=1, searching upward from pointer p with wrap.
  - There is no grant when fifo_full=1, even if a read occurs in the same cycle.
  - On a grant to requester i: fifo_write=1, fifo_data=req_data[i], req_ready[i]=1, and the pointer becomes (i+1) mod NREQ.
  - When there is no grant: fifo_write=0, and fifo_data is don't-care but held at 0.
  - At most one write per cycle.
- Read sequencing (RUN):
  - Issue fifo_read=1 when fifo_empty=0 and (buffer count + in-flight) < 2, where the buffer count is taken after the current cycle's pop.
  - fifo_read is never asserted when fifo_empty=1. A write in the same cycle does not make the FIFO readable that cycle.
  - fifo_read asserted in cycle t means fifo_dout is valid in cycle t+1. The controller captures fifo_dout into its buffer at the end of t+1.
  - In-flight is set at t and cleared at t+1.
  - Latency: a byte written in cycle t appears on out_valid no earlier than cycle t+3.
  - Sustained throughput is 1 byte per cycle when out_ready is held at 1.
- Output buffer:
  - 2-entry FIFO-ordered register pair. out_data/out_valid always present the head entry.
  - A pop happens when out_valid and out_ready are both high.
  - A capture and a pop in the same cycle leaves the count unchanged.
  - A byte is never lost or duplicated.
- Flush:
  - flush=1 in RUN moves to FLUSH next cycle. flush is ignored while already in FLUSH.
  - In FLUSH: flush_busy=1, req_ready=0, out_valid=0, and the output buffer is discarded on entry.
  - A byte still in flight at entry is discarded.
  - fifo_read=1 every cycle while fifo_empty=0; returned bytes are discarded.
  - Return to RUN in the cycle after one where fifo_empty=1 and in-flight=0.
- Simultaneous flush and grant: the write in the flush cycle is accepted, then removed by the flush.
- RST_N asserted mid-operation: the buffer and in-flight byte are lost. The FIFO keeps its contents.

Decomposition:
- Shared package fifo8_ctrl_pkg:
  - State encoding (ST_RUN=1'b0, ST_FLUSH=1'b1).
  - OBUF_DEPTH=2.
  - FIFO_CAP=255.
- One natural sub-module: rr_arbiter. Parameterised by NREQ; inputs valid vector, enable and pointer; outputs one-hot grant and next pointer. It is purely combinational and the pointer register stays in fifo8_ctrl.

Test Plan:
- Single write then drain: NREQ=2, req0 writes 0xA5 at cycle 0, out_ready=1 → out_valid=1 with out_data=0xA5 at cycle 3; fifo_empty=1 afterwards.
- Round-robin: both requesters held valid with streams 0x10.. and 0x20.. → grants alternate req0/req1; output sequence is 0x10, 0x20, 0x11, 0x21, …; no starvation.
- Full boundary:
  - With out_ready=0, write 255+ bytes → exactly 255 + 2 (buffer) + 0 more accepted.
  - req_ready=0 while fifo_full=1.
  - Releasing out_ready drains all bytes in write order.
- Backpressure: with out_ready toggling 1,0,1,0 during a burst of 0x00..0x0F → all 16 bytes delivered in order with no duplicates; out_data is stable while out_valid=1 and out_ready=0.
- Flush mid-stream:
  - Load 10 bytes, assert flush for 1 cycle → flush_busy=1, out_valid=0, req_ready=0 until fifo_empty.
  - Then flush_busy=0, and a new byte 0x5A is the next and only byte delivered.
- Reset mid-operation: deassert RST_N with 3 bytes in the FIFO and 2 in the buffer → outputs return to reset values asynchronously; after release the 3 FIFO bytes are delivered in order.
